// File: rtl/cordic_pkg.sv
// Shared constants for the cordic16 rotation core and its iteration sequencer.
//   CORDIC_W / CORDIC_AW / CORDIC_ITER : datapath width, iteration index width, iteration count
//   IDLE / RUN / CAP / DONE            : sequencer state encoding
//   CORDIC_K                           : start magnitude that cancels the 16-step CORDIC gain
//   cordic_atan()                      : atan(2**-i) in angle units (65536 units = full turn)
package cordic_pkg;

    localparam int CORDIC_W    = 16;
    localparam int CORDIC_AW   = 4;
    localparam int CORDIC_ITER = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] CAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // 0.607253 * 2**14, so the rotated vector ends with magnitude ~2**14.
    localparam logic [CORDIC_W-1:0] CORDIC_K = 16'h26dd;

    function automatic logic [CORDIC_W-1:0] cordic_atan(input logic [CORDIC_AW-1:0] i);
        logic [CORDIC_W-1:0] a;
        a = '0;
        unique case (i)
            4'd0:  a = 16'h2000;
            4'd1:  a = 16'h12e4;
            4'd2:  a = 16'h09fb;
            4'd3:  a = 16'h0511;
            4'd4:  a = 16'h028b;
            4'd5:  a = 16'h0146;
            4'd6:  a = 16'h00a3;
            4'd7:  a = 16'h0051;
            4'd8:  a = 16'h0029;
            4'd9:  a = 16'h0014;
            4'd10: a = 16'h000a;
            4'd11: a = 16'h0005;
            4'd12: a = 16'h0003;
            4'd13: a = 16'h0001;
            4'd14: a = 16'h0001;
            4'd15: a = 16'h0000;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic16.sv
// cordic16: one CORDIC micro-rotation per clock edge.
//   clock        : rising-edge clock
//   load         : start a new rotation from (K, 0, 0); the step at addr is applied in the same edge
//   addr         : iteration index i (shift amount and atan table entry)
//   endangle     : target angle
//   sin/cos      : rotated vector y/x, scaled by 2**14
//   currentangle : accumulated rotation angle
module cordic16
    import cordic_pkg::*;
#(
    parameter int W  = CORDIC_W,
    parameter int AW = CORDIC_AW
) (
    input  logic          clock,
    input  logic          load,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  endangle,
    output logic [W-1:0]  sin,
    output logic [W-1:0]  cos,
    output logic [W-1:0]  currentangle
);

    logic signed [W-1:0] x_src, y_src, z_src;
    logic signed [W-1:0] x_sh, y_sh;

    always_comb begin
        x_src = load ? $signed(CORDIC_K) : $signed(cos);
        y_src = load ? '0 : $signed(sin);
        z_src = load ? '0 : $signed(currentangle);
        x_sh  = x_src >>> addr;
        y_sh  = y_src >>> addr;
    end

    // Rotate toward the target: positive while the accumulated angle has not passed it.
    always_ff @(posedge clock) begin
        if (z_src <= $signed(endangle)) begin
            cos          <= x_src - y_sh;
            sin          <= y_src + x_sh;
            currentangle <= z_src + cordic_atan(addr);
        end else begin
            cos          <= x_src + y_sh;
            sin          <= y_src - x_sh;
            currentangle <= z_src - cordic_atan(addr);
        end
    end

endmodule

// File: rtl/cordic16_seq.sv
// cordic16_seq: self-timed wrapper around cordic16.
// Accepts an angle (in_valid/in_ready), runs the 16 micro-rotations, captures the core result
// and offers it downstream (out_valid/out_ready).
//   clock, reset           : rising-edge clock, asynchronous active-high reset
//   in_angle/in_valid      : request angle and valid
//   in_ready               : request accepted when in_valid & in_ready at an edge
//   out_sin/out_cos/out_resid, out_valid : registered result and valid
//   out_ready              : result retired when out_valid & out_ready at an edge
//   busy                   : iteration or capture in progress
module cordic16_seq
    import cordic_pkg::*;
#(
    parameter int W    = CORDIC_W,
    parameter int ITER = CORDIC_ITER,
    parameter int AW   = CORDIC_AW
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in_angle,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_sin,
    output logic [W-1:0] out_cos,
    output logic [W-1:0] out_resid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  angle_q, angle_d;
    logic          out_valid_d;
    logic          capture;
    logic          accept;

    logic          core_load;
    logic [AW-1:0] core_addr;
    logic [W-1:0]  core_sin, core_cos, core_angle;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign busy      = (state_q == RUN) || (state_q == CAP);
    assign accept    = in_valid && in_ready;
    assign core_load = (state_q == RUN) && (cnt_q == '0);
    // Hold addr at the last index in CAP; the result is sampled before that edge's update.
    assign core_addr = (state_q == CAP) ? AW'(ITER - 1) : cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        angle_d     = angle_q;
        out_valid_d = out_valid;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    angle_d = in_angle;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(ITER - 1)) begin
                    state_d = CAP;
                end
            end
            CAP: begin
                capture     = 1'b1;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        // Retire and accept on the same edge: no idle cycle between results.
                        angle_d = in_angle;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            angle_q   <= '0;
            out_valid <= 1'b0;
            out_sin   <= '0;
            out_cos   <= '0;
            out_resid <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            angle_q   <= angle_d;
            out_valid <= out_valid_d;
            if (capture) begin
                out_sin   <= core_sin;
                out_cos   <= core_cos;
                out_resid <= core_angle;
            end
        end
    end

    cordic16 #(
        .W  (W),
        .AW (AW)
    ) u_core (
        .clock        (clock),
        .load         (core_load),
        .addr         (core_addr),
        .endangle     (angle_q),
        .sin          (core_sin),
        .cos          (core_cos),
        .currentangle (core_angle)
    );

endmodule
